jk_bank_driver: RTL and testbench
=================================

# jk_bank_driver

Sequential driver for a bank of WIDTH external JK flip-flops (each with the standard JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle).
- Accepts a target value through a valid/ready handshake.
- Derives per-bit J/K drive from the excitation table, using the bank's fed-back Q.
- Drives the bank for one cycle, then checks the result, with bounded retry and a sticky error flag.
- Sits between control logic that wants a register value and a JK-flip-flop-based register bank.

## Interface
- WIDTH, 4: number of JK flip-flops driven.
- CHECK_EN, 1: 1 = verify q_fb after every drive; 0 = skip verification.
- MAX_RETRY, 2: extra drive attempts after a failed check (0..15).

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tgt_valid  in  1  target request valid.
- tgt_ready  out  1  block can accept a target.
- tgt_data  in  WIDTH  desired bank value.
- q_fb  in  WIDTH  current Q of the external bank.
- j  out  WIDTH  registered J drive to the bank.
- k  out  WIDTH  registered K drive to the bank.
- done  out  1  one-cycle pulse when a request completes, pass or fail.
- err  out  1  sticky flag: request finished without q_fb matching target.
- err_clr  in  1  synchronous clear of err.

## Operation
- States: IDLE, DRIVE, CHECK.
- Reset (async, immediate):
  - state = IDLE; j = k = 0; done = 0; err = 0.
  - Retry count and held target cleared to 0.
  - tgt_ready = 1 once state is IDLE, since tgt_ready is decoded from state.
- IDLE:
  - tgt_ready = 1; j = k = 0, so the bank holds.
  - On tgt_valid & tgt_ready: latch tgt_data, load j/k from the excitation of q_fb versus tgt_data, clear the retry count, go to DRIVE.
- Excitation per bit (current q -> target t), don't-cares resolved to hold; 11 is never driven:
  - 0->0: J=0 K=0
  - 0->1: J=1 K=0
  - 1->0: J=0 K=1
  - 1->1: J=0 K=0
- DRIVE (exactly one cycle):
  - j/k are presented; the bank samples them at the edge ending DRIVE.
  - j/k return to 0 at that edge.
  - Next state is CHECK if CHECK_EN = 1. Otherwise IDLE, with done pulsed.
- CHECK:
  - j = k = 0; compare q_fb with the held target.
  - Match: go to IDLE; done = 1 next cycle.
  - Mismatch with retry count < MAX_RETRY: increment the count, reload j/k from the excitation of the current q_fb, go to DRIVE.
  - Mismatch with retry count = MAX_RETRY: set err, go to IDLE; done = 1 next cycle.
- err:
  - Set only by a final mismatch; cleared by err_clr.
  - If set and clear coincide in the same cycle, set wins.
- tgt_valid outside IDLE is ignored. The requester holds tgt_data until accepted.
- tgt_data is not re-sampled after acceptance. q_fb changes during DRIVE do not affect the j/k already registered.

## Timing
- Accept at edge E0:
  - DRIVE during cycle E0..E1; bank updates at E1.
  - CHECK during E1..E2.
  - done high E2..E3, with tgt_ready high in that same cycle.
- Minimum accept-to-accept spacing:
  - CHECK_EN=1: 3 cycles.
  - CHECK_EN=0: 2 cycles (done high E1..E2).
- Each retry adds 2 cycles.
- Worst-case latency with CHECK_EN=1: 3 + 2*MAX_RETRY cycles.
- A back-to-back request may be accepted in the cycle where done is high.
- q_fb is sampled combinationally in IDLE (on accept) and in CHECK. It must be stable one cycle after the bank's clock edge.
- Reset asserted mid-DRIVE drops j/k to 0 asynchronously, so the bank receives hold. No done is issued for the aborted request.

## Test plan
- WIDTH=4, bank modelled as 4 behavioural JK FFs. After reset: j=k=0, tgt_ready=1, done=0, err=0; bank = 0000. Request tgt=1010 -> during DRIVE j=1010, k=0000; q_fb=1010 in CHECK; done pulses 3 cycles after accept; err=0.
- Bank = 1010, request 0110 -> j=0100, k=1000; q_fb=0110; done, err=0; j&k never both 1 on any bit.
- Bank = 0110, request 0110 -> j=k=0000 during DRIVE; done after 3 cycles.
- Force bank bit0 stuck at 0, MAX_RETRY=2, request 0001 -> DRIVE occurs 3 times, each with j=0001; err=1 and done pulse at cycle 7 after accept. Then err_clr=1 for one cycle -> err=0.
- CHECK_EN=0, back-to-back requests 1111 then 0000 with tgt_valid held -> accepts 2 cycles apart; j=1111 then k=1111; bank ends at 0000.
- Assert reset during DRIVE of request 1100 from bank 0000 -> j/k go to 0 immediately; no done; state IDLE; tgt_ready=1 after reset release; bank remains 0000.

Source files
------------

// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - drives a bank of external JK flip-flops to a requested value with check and retry
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int CHECK_EN  = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_tgt_valid,
  output logic             o_tgt_ready,
  input  logic [WIDTH-1:0] i_tgt_data,
  input  logic [WIDTH-1:0] i_q_fb,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k,
  output logic             o_done,
  output logic             o_err,
  input  logic             i_err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

  state_t           r_state;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_tgt;
  logic [3:0]       r_retry;
  logic             r_done;
  logic             r_err;

  logic [WIDTH-1:0] w_j_acc;
  logic [WIDTH-1:0] w_k_acc;
  logic [WIDTH-1:0] w_j_rty;
  logic [WIDTH-1:0] w_k_rty;
  logic             w_match;

  // Excitation: set bits that must rise, clear bits that must fall, hold the rest;
  // J and K are never both asserted on one bit.
  assign w_j_acc = ~i_q_fb & i_tgt_data;
  assign w_k_acc = i_q_fb & ~i_tgt_data;
  assign w_j_rty = ~i_q_fb & r_tgt;
  assign w_k_rty = i_q_fb & ~r_tgt;
  assign w_match = (i_q_fb == r_tgt);

  assign o_tgt_ready = (r_state == IDLE);
  assign o_j         = r_j;
  assign o_k         = r_k;
  assign o_done      = r_done;
  assign o_err       = r_err;

  // Request sequencer: accept, drive for one cycle, optionally verify and retry.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_j     <= '0;
      r_k     <= '0;
      r_tgt   <= '0;
      r_retry <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Clear first so a final mismatch in this same cycle overrides it.
      if (i_err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_j <= '0;
          r_k <= '0;
          if (i_tgt_valid) begin
            r_tgt   <= i_tgt_data;
            r_j     <= w_j_acc;
            r_k     <= w_k_acc;
            r_retry <= '0;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          r_j <= '0;
          r_k <= '0;
          if (CHECK_EN != 0) begin
            r_state <= CHECK;
          end else begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        CHECK: begin
          r_j <= '0;
          r_k <= '0;
          if (w_match) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (r_retry < MAX_R) begin
            r_retry <= r_retry + 4'd1;
            r_j     <= w_j_rty;
            r_k     <= w_k_rty;
            r_state <= DRIVE;
          end else begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_j     <= '0;
          r_k     <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - scoreboard bench for jk_bank_driver with behavioural JK banks
module tb_jk_bank_driver;

  typedef struct {
    logic [3:0] q;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       bank_clr;
  logic [3:0] stuck;

  logic       tv_a, rdy_a, done_a, err_a, ec_a;
  logic [3:0] td_a, j_a, k_a, bq_a;
  logic       tv_b, rdy_b, done_b, err_b, ec_b;
  logic [3:0] td_b, j_b, k_b, bq_b;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_vec;
  int   n_miss;

  jk_bank_driver #(.WIDTH(4), .CHECK_EN(1), .MAX_RETRY(2)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_tgt_valid(tv_a), .o_tgt_ready(rdy_a),
    .i_tgt_data(td_a), .i_q_fb(bq_a), .o_j(j_a), .o_k(k_a),
    .o_done(done_a), .o_err(err_a), .i_err_clr(ec_a)
  );

  jk_bank_driver #(.WIDTH(4), .CHECK_EN(0), .MAX_RETRY(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_tgt_valid(tv_b), .o_tgt_ready(rdy_b),
    .i_tgt_data(td_b), .i_q_fb(bq_b), .o_j(j_b), .o_k(k_b),
    .o_done(done_b), .o_err(err_b), .i_err_clr(ec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j, input logic [3:0] k);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b00: n[i] = q[i];
        2'b01: n[i] = 1'b0;
        2'b10: n[i] = 1'b1;
        default: n[i] = ~q[i];
      endcase
    end
    return n;
  endfunction

  // External banks; not reset by the driver's reset.
  always @(posedge clk) begin
    if (bank_clr) begin
      bq_a <= 4'h0;
      bq_b <= 4'h0;
    end else begin
      bq_a <= jk_next(bq_a, j_a, k_a) & ~stuck;
      bq_b <= jk_next(bq_b, j_b, k_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on each completion.
  always @(negedge clk) begin
    exp_t e;
    if (done_a === 1'b1) begin
      if (sb_a.size() == 0) check("sb_a_spurious_done", 1, 0);
      else begin
        e = sb_a.pop_front();
        check("sb_a_err", err_a, e.err);
        check("sb_a_bank", bq_a, e.q);
      end
    end
    if (done_b === 1'b1) begin
      if (sb_b.size() == 0) check("sb_b_spurious_done", 1, 0);
      else begin
        e = sb_b.pop_front();
        check("sb_b_err", err_b, e.err);
        check("sb_b_bank", bq_b, e.q);
      end
    end
  end

  // Called at a negedge with DUT A idle; returns at the negedge where done is seen.
  task automatic req_a(input logic [3:0] t, input logic [3:0] ej, input logic [3:0] ek,
                       input logic eerr, input logic [3:0] efinal, input int elat, input int edrv);
    int  cyc;
    int  drv;
    logic seen;
    check("req_ready", rdy_a, 1);
    tv_a = 1'b1;
    td_a = t;
    sb_a.push_back('{q: efinal, err: eerr});
    @(negedge clk);
    tv_a = 1'b0;
    cyc  = 1;
    check("drive_j", j_a, ej);
    check("drive_k", k_a, ek);
    check("drive_busy", rdy_a, 0);
    drv  = ((j_a | k_a) != 4'h0) ? 1 : 0;
    seen = done_a;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      check("jk_overlap", j_a & k_a, 0);
      if ((j_a | k_a) != 4'h0) begin
        drv++;
        check("retry_j", j_a, ej);
      end
      seen = done_a;
    end
    check("latency", cyc, elat);
    check("drive_count", drv, edrv);
    check("done_ready", rdy_a, 1);
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    rst      = 1'b1;
    bank_clr = 1'b1;
    stuck    = 4'h0;
    tv_a = 1'b0; td_a = 4'h0; ec_a = 1'b0;
    tv_b = 1'b0; td_b = 4'h0; ec_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_j", j_a, 0);
    check("rst_k", k_a, 0);
    check("rst_ready", rdy_a, 1);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_b_ready", rdy_b, 1);
    rst      = 1'b0;
    bank_clr = 1'b0;
    @(negedge clk);
    check("bank_init", bq_a, 0);

    req_a(4'b1010, 4'b1010, 4'b0000, 1'b0, 4'b1010, 3, 1);
    req_a(4'b0110, 4'b0100, 4'b1000, 1'b0, 4'b0110, 3, 1);
    req_a(4'b0110, 4'b0000, 4'b0000, 1'b0, 4'b0110, 3, 0);

    stuck = 4'b0001;
    req_a(4'b0001, 4'b0001, 4'b0110, 1'b1, 4'b0000, 7, 3);
    check("err_sticky", err_a, 1);
    ec_a = 1'b1;
    @(negedge clk);
    ec_a = 1'b0;
    check("err_cleared", err_a, 0);
    stuck = 4'h0;

    // Back-to-back with valid held on the drive-only instance.
    tv_b = 1'b1;
    td_b = 4'b1111;
    sb_b.push_back('{q: 4'b1111, err: 1'b0});
    @(negedge clk);
    check("b_drive1_j", j_b, 4'b1111);
    check("b_drive1_k", k_b, 4'b0000);
    check("b_busy", rdy_b, 0);
    td_b = 4'b0000;
    sb_b.push_back('{q: 4'b0000, err: 1'b0});
    @(negedge clk);
    check("b_done1", done_b, 1);
    check("b_ready1", rdy_b, 1);
    @(negedge clk);
    tv_b = 1'b0;
    check("b_drive2_j", j_b, 4'b0000);
    check("b_drive2_k", k_b, 4'b1111);
    @(negedge clk);
    check("b_done2", done_b, 1);
    check("b_bank_end", bq_b, 4'b0000);

    // Reset while DRIVE is presenting j/k.
    @(negedge clk);
    tv_a = 1'b1;
    td_a = 4'b1100;
    @(negedge clk);
    tv_a = 1'b0;
    check("abort_drive_j", j_a, 4'b1100);
    rst = 1'b1;
    #1;
    check("abort_j", j_a, 0);
    check("abort_k", k_a, 0);
    check("abort_ready", rdy_a, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", done_a, 0);
    end
    check("abort_bank", bq_a, 4'b0000);
    check("abort_ready_after", rdy_a, 1);

    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
